// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronised and glitch-filtered pins, 11-bit frame check, inactivity
// timeout, E0/F0 prefix folding and a show-ahead FIFO of {ext, brk, code} events.
module ps2_scan_rx #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DATA,
  input  logic                          rd_en,
  output logic [9:0]                    dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          err,
  output logic [1:0]                    err_type,
  output logic                          overflow,
  output logic [3:0]                    COUNT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = $clog2(FILTER_LEN);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q;
  logic [FW-1:0] flt_cnt_q;
  logic [9:0]    sh_q;
  logic [TW-1:0] to_cnt_q;
  logic          ext_q, brk_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic [9:0]    mem [FIFO_DEPTH];

  logic       flt_done, bit_tick, stop_tick, bad_ss, bad_par, frame_bad;
  logic       timeout, is_prefix, push, pop, do_wr;
  logic [7:0] rx_byte;

  always_comb begin
    flt_done  = (clk_s2_q != filt_q) && (flt_cnt_q == FW'(FILTER_LEN - 1));
    bit_tick  = flt_done && filt_q;
    stop_tick = bit_tick && (COUNT == 4'd10);
    // At the stop tick sh_q holds bits 0..9; the stop bit is still on the synchroniser.
    rx_byte   = sh_q[8:1];
    bad_ss    = sh_q[0] | ~dat_s2_q;
    bad_par   = ~(^sh_q[9:1]);
    frame_bad = bad_ss | bad_par;
    is_prefix = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
    push      = stop_tick && !frame_bad && !is_prefix;
    timeout   = (COUNT != 4'd0) && !bit_tick && (to_cnt_q == TW'(TIMEOUT_CYCLES));
    pop       = rd_en && !empty;
    do_wr     = push && (!full || pop);
    empty     = (level_q == '0);
    full      = (level_q == (AW + 1)'(FIFO_DEPTH));
    level     = level_q;
    dout      = empty ? 10'd0 : mem[rd_ptr_q];
  end

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr_q] <= {ext_q, brk_q, rx_byte};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
      sh_q      <= '0;
      COUNT     <= 4'd0;
      to_cnt_q  <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      err       <= 1'b0;
      err_type  <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DATA;
      dat_s2_q <= dat_s1_q;

      if (clk_s2_q == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_done) begin
        filt_q    <= clk_s2_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FW'(1);
      end

      if (bit_tick) begin
        COUNT <= stop_tick ? 4'd0 : COUNT + 4'd1;
        if (!stop_tick) sh_q <= {dat_s2_q, sh_q[9:1]};
      end else if (timeout) begin
        COUNT <= 4'd0;
      end

      if (COUNT == 4'd0 || bit_tick || timeout) to_cnt_q <= '0;
      else                                      to_cnt_q <= to_cnt_q + TW'(1);

      err <= 1'b0;
      if (stop_tick) begin
        if (frame_bad) begin
          err      <= 1'b1;
          err_type <= bad_ss ? 2'b10 : 2'b01;
          ext_q    <= 1'b0;
          brk_q    <= 1'b0;
        end else if (rx_byte == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end else if (timeout) begin
        err      <= 1'b1;
        err_type <= 2'b11;
        ext_q    <= 1'b0;
        brk_q    <= 1'b0;
      end

      overflow <= push && full && !pop;
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_wr && !pop)      level_q <= level_q + (AW + 1)'(1);
      else if (!do_wr && pop) level_q <= level_q - (AW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Randomised bench for ps2_scan_rx: drives PS/2 frames on the pins and compares against a
// queue-based event model.
module tb_ps2_scan_rx;

  localparam int unsigned FL    = 4;
  localparam int unsigned TO    = 300;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned HALF  = 20;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, rd_en;
  logic [9:0] dout;
  logic       empty, full, err, overflow;
  logic [3:0] level;
  logic [1:0] err_type;
  logic [3:0] count;

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .level(level), .err(err),
    .err_type(err_type), .overflow(overflow), .COUNT(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cycles = 0, ovf_cycles = 0;

  // model
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk;
  logic [1:0] m_err_type = 2'b00;
  int         m_err_cycles = 0, m_ovf_cycles = 0;

  always @(negedge clk) begin
    if (err)      err_cycles++;
    if (overflow) ovf_cycles++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] m_head();
    return (exp_q.size() != 0) ? exp_q[0] : 10'd0;
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, "_level"}, level, exp_q.size());
    check_eq({tag, "_dout"}, dout, m_head());
    check_eq({tag, "_empty"}, empty, exp_q.size() == 0);
    check_eq({tag, "_full"}, full, exp_q.size() == DEPTH);
    check_eq({tag, "_count"}, count, 0);
    check_eq({tag, "_errtype"}, err_type, m_err_type);
    check_eq({tag, "_errpulses"}, err_cycles, m_err_cycles);
    check_eq({tag, "_ovfpulses"}, ovf_cycles, m_ovf_cycles);
  endtask

  // One PS/2 bit: data set during the high phase, then a falling pin edge.
  task automatic send_bit(input bit b, input bit glitch, input bit pop_stop);
    ps2_data = b;
    if (glitch) begin
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (FL - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b0;
    if (pop_stop) begin
      // rd_en lands on the same edge as the stop-bit FIFO write (2 sync + FL filter cycles).
      repeat (FL + 1) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (HALF - FL - 2) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
  task automatic do_frame(input logic [7:0] b, input int kind, input bit glitch, input bit pop_stop);
    logic [10:0] fr;
    fr[0]   = (kind == 3);
    fr[8:1] = b;
    fr[9]   = ~(^b) ^ (kind == 1);
    fr[10]  = (kind != 2);
    for (int i = 0; i < 11; i++) send_bit(fr[i], glitch, pop_stop && (i == 10));
    if (pop_stop && exp_q.size() != 0) void'(exp_q.pop_front());
    if (kind != 0) begin
      m_err_cycles++;
      m_err_type = (kind == 1) ? 2'b01 : 2'b10;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (exp_q.size() == DEPTH) m_ovf_cycles++;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 0;
      m_brk = 0;
    end
    repeat (10) @(negedge clk);
    check_state("frame");
  endtask

  task automatic pop_one();
    check_eq("pop_head", dout, m_head());
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check_eq("pop_level", level, exp_q.size());
  endtask

  task automatic drain();
    while (exp_q.size() != 0) pop_one();
  endtask

  initial begin
    logic [7:0] b;
    int kind;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset");
    check_eq("reset_err", err, 0);
    check_eq("reset_ovf", overflow, 0);

    // make codes
    do_frame(8'h75, 0, 0, 0);
    do_frame(8'hAE, 0, 0, 0);
    check_eq("plan_make_level", level, 2);
    check_eq("plan_make_dout", dout, 10'h075);
    pop_one();
    check_eq("plan_make_dout2", dout, 10'h0AE);
    drain();

    // prefixes
    do_frame(8'hF0, 0, 0, 0); do_frame(8'h75, 0, 0, 0);
    check_eq("plan_brk", dout, 10'h175);
    drain();
    do_frame(8'hE0, 0, 0, 0); do_frame(8'hF0, 0, 0, 0); do_frame(8'h74, 0, 0, 0);
    check_eq("plan_ext_brk", dout, 10'h374);
    drain();
    do_frame(8'hF0, 0, 0, 0); do_frame(8'hE0, 0, 0, 0); do_frame(8'h74, 0, 0, 0);
    check_eq("plan_brk_ext", dout, 10'h374);
    drain();

    // errors
    do_frame(8'h75, 1, 0, 0);
    check_eq("plan_parity_type", err_type, 2'b01);
    do_frame(8'h75, 2, 0, 0);
    check_eq("plan_stop_type", err_type, 2'b10);
    do_frame(8'hF0, 0, 0, 0); do_frame(8'h33, 1, 0, 0); do_frame(8'h1C, 0, 0, 0);
    check_eq("plan_brk_cleared", dout, 10'h01C);
    drain();

    // timeout after 5 bits
    send_bit(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 0);
    repeat (3) @(negedge clk);
    check_eq("timeout_count5", count, 5);
    repeat (TO + 20) @(negedge clk);
    m_err_cycles++; m_err_type = 2'b11; m_ext = 0; m_brk = 0;
    check_state("timeout");
    do_frame(8'h1C, 0, 0, 0);
    check_eq("plan_after_timeout", dout, 10'h01C);
    drain();

    // overflow, then push+pop on the same edge while full
    for (int i = 0; i < DEPTH + 1; i++) begin
      do_frame(8'h10 + 8'(i), 0, 0, 0);
      if (i == DEPTH - 1) check_eq("plan_full", full, 1);
    end
    check_eq("plan_ovf_pulses", ovf_cycles, 1);
    do_frame(8'h55, 0, 0, 1);
    check_eq("plan_pushpop_level", level, DEPTH);
    drain();

    // glitches inside a frame
    do_frame(8'h5A, 0, 1, 0);
    check_eq("plan_glitch", dout, 10'h05A);
    drain();

    // reset mid-frame
    send_bit(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); m_ext = 0; m_brk = 0; m_err_type = 2'b00;
    @(negedge clk);
    check_state("midreset");
    do_frame(8'h2B, 0, 0, 0);
    check_eq("plan_after_reset", dout, 10'h02B);

    // randomised traffic
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 7))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      kind = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_frame(b, kind, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      for (int k = $urandom_range(0, 2); k > 0; k--) pop_one();
    end
    drain();
    pop_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

Parametrised PS/2 keyboard receiver with glitch filtering, frame checking, inactivity timeout, make/break/extended prefix decoding and a show-ahead scan-code FIFO. It sits between the PS/2 pins and the key-handling logic. Consumers read complete key events, `{ext, brk, code}`, instead of raw 11-bit frames. It replaces the single-register, no-recovery keyboard receiver.

## Interface
Parameters:
- `FILTER_LEN`, default 4: consecutive equal samples required before the filtered PS2_CLK may change (≥2).
- `TIMEOUT_CYCLES`, default 20000: CLK cycles without a filtered falling edge mid-frame before the frame is abandoned.
- `FIFO_DEPTH`, default 8: event FIFO entries (power of 2, ≥2).

Ports:
- `CLK`  in  1  system clock. One clock; every flop is on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `PS2_CLK`  in  1  asynchronous PS/2 clock pin.
- `PS2_DATA`  in  1  asynchronous PS/2 data pin.
- `rd_en`  in  1  pop request. Ignored when `empty`.
- `dout`  out  10  head entry `{ext, brk, code[7:0]}`. Valid while `!empty`.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `level`  out  $clog2(FIFO_DEPTH)+1  number of entries held.
- `err`  out  1  one-cycle pulse when a frame is rejected.
- `err_type`  out  2  cause, valid with `err`: 01 parity, 10 start/stop, 11 timeout. Holds its last value otherwise.
- `overflow`  out  1  one-cycle pulse when a decoded event is dropped because the FIFO is full.
- `COUNT`  out  4  bits received in the current frame (0..10), for debug.

## Operation
- **Input stage:** PS2_CLK and PS2_DATA each pass through a 2-FF synchroniser. The filtered clock takes the synchronised clock's value only after FILTER_LEN consecutive equal samples. A falling edge of the filtered clock is a `bit_tick`.
- **Bit capture:** on each `bit_tick`, the synchronised data bit is shifted in LSB-first and COUNT increments. Bit 0 is start, bits 1–8 are data, bit 9 is parity, bit 10 is stop.
- **Frame check:** done on the `bit_tick` that carries the stop bit. Start must be 0, stop must be 1, and the nine bits data+parity must have odd parity.
  - Start/stop failure takes precedence over parity failure.
  - On failure: `err` pulses, the frame is discarded, the ext/brk pending flags are cleared, and COUNT returns to 0.
- **Timeout:** while COUNT≠0, a counter runs. It clears on every `bit_tick`. When it reaches TIMEOUT_CYCLES: `err` pulses with 11, COUNT returns to 0, and the pending flags are cleared.
- **Decode of a good byte:**
  - 0xE0 sets ext_pend. 0xF0 sets brk_pend. Neither prefix is pushed.
  - Any other byte pushes `{ext_pend, brk_pend, byte}` and then clears both flags.
  - Prefixes are accepted in either order.
- **FIFO:** show-ahead. `dout` is the oldest entry.
  - `rd_en & !empty` pops.
  - A push while full, with no pop in the same cycle, is dropped: `overflow` pulses and the contents are unchanged.
  - A push and a pop in the same cycle both proceed, including when full; `level` is then unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **Reset:** clears the synchronisers, which go to 1. The filter output goes to 1, COUNT to 0, the timeout counter to 0, the pending flags to 0, and the FIFO pointers to 0.
  - Reset values: `empty`=1, `full`=0, `level`=0, `err`=0, `err_type`=00, `overflow`=0, `COUNT`=0, `dout`=0.
  - A frame in progress at reset is lost. Reception restarts at the next start bit.

## Timing
- **Pin to tick:** a pin falling edge produces `bit_tick` 2+FILTER_LEN cycles later (±1 for synchroniser phase). Data is sampled in that same cycle, so PS2_DATA must be stable from 2 cycles before the pin edge until the tick.
- **Glitch rejection:** a PS2_CLK glitch shorter than FILTER_LEN cycles produces no tick.
- **Stop bit to FIFO:** the stop-bit tick is cycle T. The check and decode happen at T. The FIFO write happens at T+1: `empty`, `level` and `dout` update at T+1. `err` and `overflow` assert at T+1 for exactly 1 cycle.
- **Pop:** `rd_en` sampled high at cycle P gives the new `dout`/`level` at P+1.
- **Timeout pulse:** `err` asserts the cycle after the counter reaches TIMEOUT_CYCLES.

## Test plan
1. **Make codes:** frames 0x75 (parity 0), then 0xAE (parity 0), no reads → `level`=2, `dout`=0x075; `rd_en` for one cycle → `dout`=0x0AE; `err` never pulses.
2. **Break and extended prefixes:**
   - Frames F0 (parity 1), then 75 → single entry 0x175.
   - Frames E0, F0, 74 → single entry 0x374.
   - Frames F0, E0, 74 → also 0x374.
3. **Errors:**
   - Frame 0x75 with parity 1 → `err`=1 with `err_type`=01, `level` unchanged.
   - Stop bit 0 → `err_type`=10.
   - Pending F0 followed by a bad frame, then good 0x1C → entry 0x01C (brk cleared).
4. **Timeout:** 5 bits then idle for TIMEOUT_CYCLES → `err_type`=11 and `COUNT`=0; a following clean 0x1C frame → entry 0x01C.
5. **Overflow:** FIFO_DEPTH+1 frames with no reads → `full`=1 after the 8th; `overflow` pulses on the 9th; 8 pops return entries in order, and the 9th event is absent. Push and pop in the same cycle while full → `level` stays 8.
6. **Glitch and reset:**
   - PS2_CLK low pulses of FILTER_LEN−1 cycles inside a frame → COUNT unaffected, frame decodes correctly.
   - `RST` asserted after bit 4 → all outputs return to reset values; the next full frame decodes correctly.
